block_grid_ctrl: RTL and testbench
==================================

# block_grid_ctrl

Parametrised falling-block game controller, successor to the fixed 4-column controller. It owns a COLS×ROWS occupancy grid and moves one falling block under gravity and key control. It lands blocks, clears full rows, keeps score, and flags game over when the spawn cell is blocked. It sits between the top-level game state machine and key debouncers on one side and the display column driver on the other.

## Interface
- COLS, 4: grid width in columns (≥2).
- ROWS, 8: grid height in rows (≥2).
- DROP_TICKS, 25_000_000: clock cycles per gravity step (≥2).
- SPAWN_COL, 1: spawn column (<COLS).
- CLK_50M  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- game_state  in  2  00 START, 01 PLAY, 10/11 OVER.
- left_key_press, right_key_press, down_key_press  in  1 each  debounced single-cycle pulses.
- disp  out  COLS*ROWS  settled grid OR falling block. Cell (x,y) is bit x*ROWS+y, with y=0 as the top row.
- block_x  out  $clog2(COLS)  falling block column.
- block_y  out  $clog2(ROWS)  falling block row.
- score  out  16  rows cleared, saturating at 16'hFFFF.
- line_clr  out  1  one-cycle pulse per cleared row.
- game_over  out  1  sticky until START.

## Operation
- FSM states: WAIT, SPAWN, FALL, LAND, SCAN, SHIFT, DEAD. Reset state is WAIT.
- game_state START, any FSM state:
  - Clear the grid, score, drop counter and game_over.
  - Set the block to (SPAWN_COL,0) and go to WAIT.
- game_state OVER: freeze all registers. line_clr=0.
- game_state PLAY:
  - WAIT → SPAWN.
  - SPAWN:
    - If cell (SPAWN_COL,0) is occupied: set game_over=1 and go to DEAD.
    - Otherwise: block=(SPAWN_COL,0), drop counter=0, go to FALL.
  - FALL, step condition: counter==DROP_TICKS-1 or down_key_press. Both in the same cycle give one step only.
    - Step: if y==ROWS-1 or cell (x,y+1) is occupied, go to LAND. Otherwise y←y+1. Counter←0 in both cases.
    - No step: counter increments.
    - left_key_press moves x←x-1 only if x>0 and the target cell is empty.
    - right_key_press moves x←x+1 only if x<COLS-1 and the target cell is empty.
    - Left has priority over right.
    - Any step in a cycle suppresses lateral keys in that cycle.
  - LAND: set grid cell (x,y). Go to SCAN with row pointer r=ROWS-1 if ROW_CLEAR_EN is defined, else go to SPAWN.
  - SCAN:
    - Row r full in all COLS columns: go to SHIFT.
    - Not full, r==0: go to SPAWN.
    - Not full, r>0: r←r-1.
  - SHIFT, one cycle:
    - Every row k≤r takes row k-1; row 0 becomes empty.
    - line_clr=1 and score saturating-increments.
    - Return to SCAN with r unchanged, so the row is rechecked.
  - DEAD: hold until START.
- disp = grid | onehot(x,y) while in FALL. In all other states disp = grid.
- Keys arriving outside FALL are dropped.

## Timing
- Reset values: disp=0, grid=0, block_x=SPAWN_COL, block_y=0, score=0, line_clr=0, game_over=0, counter=0, FSM=WAIT.
- Reset mid-operation returns all of the above immediately, with no completion of a shift in progress.
- All outputs are registered and update one cycle after the causing input or tick.
- PLAY from WAIT: the block is visible in disp 2 cycles after game_state=01 is first sampled.
- Gravity: one row per DROP_TICKS cycles in FALL. The counter restarts on spawn and after every step.
- Landing to next spawn without clearing: LAND, then SCAN over ROWS rows, then SPAWN (ROWS+2 cycles).
- Each cleared row adds one SHIFT cycle plus one rescan cycle.
- game_over rises in the cycle after SPAWN detects the blocked cell.

## Configuration
- ROW_CLEAR_EN defined: SCAN/SHIFT logic is present; score and line_clr are live.
- ROW_CLEAR_EN undefined:
  - LAND goes directly to SPAWN and rows never clear.
  - score and line_clr are tied to 0, and the SCAN/SHIFT states are not synthesised.

## Test plan
Bench parameters: COLS=4, ROWS=8, DROP_TICKS=4, SPAWN_COL=1, ROW_CLEAR_EN defined.
- RST, then game_state=01: after 2 cycles disp=bit 8. block_y reaches 7 after 28 further cycles, then disp bit 15 is settled.
- Block at x=0 with left pulse: x stays 0. Block at x=3 with right pulse: x stays 3. Left into an occupied cell: x unchanged. Tick and left in the same cycle: only y increments.
- Land blocks at x=0,1,2,3 in row 7: the last landing gives one line_clr pulse, score=1, and bits 7/15/23/31 clear.
- Occupied row 6 over a full row 7: after the clear, row 6 contents appear in row 7.
- Stack column 1 to row 0: the next SPAWN sets game_over=1, which holds in PLAY. game_state=00 clears grid, score and game_over.
- RST asserted mid-fall or during SHIFT: all outputs are at reset values before the next clock edge.

Source files
------------

// File: rtl/block_grid_ctrl.sv
// Falling-block controller: owns a COLS x ROWS occupancy grid, drives one block under gravity and keys.
// Row clearing (SCAN/SHIFT, score, line_clr) is present only when ROW_CLEAR_EN is defined.
module block_grid_ctrl #(
    parameter int COLS       = 4,
    parameter int ROWS       = 8,
    parameter int DROP_TICKS = 25_000_000,
    parameter int SPAWN_COL  = 1
) (
    input  logic                      CLK_50M,
    input  logic                      RST,
    input  logic [1:0]                game_state,
    input  logic                      left_key_press,
    input  logic                      right_key_press,
    input  logic                      down_key_press,
    output logic [COLS*ROWS-1:0]      disp,
    output logic [$clog2(COLS)-1:0]   block_x,
    output logic [$clog2(ROWS)-1:0]   block_y,
    output logic [15:0]               score,
    output logic                      line_clr,
    output logic                      game_over
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int CW = $clog2(DROP_TICKS);
    localparam logic [XW-1:0]   SPAWN_X   = XW'(SPAWN_COL);
    localparam logic [XW-1:0]   MAX_X     = XW'(COLS - 1);
    localparam logic [YW-1:0]   MAX_Y     = YW'(ROWS - 1);
    localparam logic [CW-1:0]   LAST_TICK = CW'(DROP_TICKS - 1);
    localparam logic [ROWS-1:0] ONE_ROW   = ROWS'(1);

    typedef enum logic [2:0] {WAIT, SPAWN, FALL, LAND, SCAN, SHIFT, DEAD} state_t;

    state_t          state;
    logic [ROWS-1:0] grid [COLS];
    logic [CW-1:0]   counter;
    logic            step;
    logic            blocked_below;

    assign step = (counter == LAST_TICK) || down_key_press;
    assign blocked_below = (block_y == MAX_Y) || grid[block_x][block_y + YW'(1)];

`ifdef ROW_CLEAR_EN
    localparam logic [ROWS-1:0] ALL_ROWS = '1;
    logic [YW-1:0]   scan_r;
    logic [15:0]     score_q;
    logic            line_clr_q;
    logic            row_full;
    logic [ROWS-1:0] keep;

    // Rows strictly below scan_r are untouched by a shift; rows 0..scan_r move down by one.
    assign keep = (ALL_ROWS << scan_r) << 1;

    always_comb begin
        row_full = 1'b1;
        for (int unsigned c = 0; c < COLS; c++)
            row_full = row_full & grid[c][scan_r];
    end

    assign score    = score_q;
    assign line_clr = line_clr_q;
`else
    assign score    = '0;
    assign line_clr = 1'b0;
`endif

    always_comb begin
        disp = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            disp[c*ROWS +: ROWS] = grid[c];
            if (state == FALL && block_x == XW'(c))
                disp[c*ROWS +: ROWS] = grid[c] | (ONE_ROW << block_y);
        end
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state     <= WAIT;
            for (int unsigned c = 0; c < COLS; c++)
                grid[c] <= '0;
            block_x   <= SPAWN_X;
            block_y   <= '0;
            counter   <= '0;
            game_over <= 1'b0;
`ifdef ROW_CLEAR_EN
            scan_r     <= MAX_Y;
            score_q    <= '0;
            line_clr_q <= 1'b0;
`endif
        end else begin
`ifdef ROW_CLEAR_EN
            line_clr_q <= 1'b0;
`endif
            if (game_state == 2'b00) begin
                state     <= WAIT;
                for (int unsigned c = 0; c < COLS; c++)
                    grid[c] <= '0;
                block_x   <= SPAWN_X;
                block_y   <= '0;
                counter   <= '0;
                game_over <= 1'b0;
`ifdef ROW_CLEAR_EN
                score_q   <= '0;
`endif
            end else if (game_state == 2'b01) begin
                case (state)
                    WAIT: state <= SPAWN;
                    SPAWN: begin
                        if (grid[SPAWN_X][0]) begin
                            game_over <= 1'b1;
                            state     <= DEAD;
                        end else begin
                            block_x <= SPAWN_X;
                            block_y <= '0;
                            counter <= '0;
                            state   <= FALL;
                        end
                    end
                    FALL: begin
                        // A gravity or down step owns the cycle; lateral keys only act otherwise.
                        if (step) begin
                            counter <= '0;
                            if (blocked_below)
                                state <= LAND;
                            else
                                block_y <= block_y + YW'(1);
                        end else begin
                            counter <= counter + CW'(1);
                            if (left_key_press) begin
                                if (block_x != '0 && !grid[block_x - XW'(1)][block_y])
                                    block_x <= block_x - XW'(1);
                            end else if (right_key_press) begin
                                if (block_x != MAX_X && !grid[block_x + XW'(1)][block_y])
                                    block_x <= block_x + XW'(1);
                            end
                        end
                    end
                    LAND: begin
                        grid[block_x][block_y] <= 1'b1;
`ifdef ROW_CLEAR_EN
                        scan_r <= MAX_Y;
                        state  <= SCAN;
`else
                        state  <= SPAWN;
`endif
                    end
`ifdef ROW_CLEAR_EN
                    SCAN: begin
                        if (row_full)
                            state <= SHIFT;
                        else if (scan_r == '0)
                            state <= SPAWN;
                        else
                            scan_r <= scan_r - YW'(1);
                    end
                    SHIFT: begin
                        for (int unsigned c = 0; c < COLS; c++)
                            grid[c] <= (grid[c] & keep) | ((grid[c] << 1) & ~keep);
                        line_clr_q <= 1'b1;
                        if (score_q != 16'hFFFF)
                            score_q <= score_q + 16'd1;
                        state <= SCAN;
                    end
`endif
                    DEAD: state <= DEAD;
                    default: state <= WAIT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_block_grid_ctrl.sv
// Self-checking bench for block_grid_ctrl: directed scenarios plus random play against a
// schedule-based model; row-clear expectations follow whether ROW_CLEAR_EN is defined.
module tb_block_grid_ctrl;
    localparam int COLS = 4, ROWS = 8, DT = 4, SPAWN_COL = 1, N = COLS * ROWS;
`ifdef ROW_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_FALLING = 1, M_PIPE = 2, M_DEAD = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   gs;
    logic         lk, rk, dk;
    logic [N-1:0] disp;
    logic [1:0]   block_x;
    logic [2:0]   block_y;
    logic [15:0]  score;
    logic         line_clr, game_over;

    int n_checks = 0;
    int n_err = 0;

    block_grid_ctrl #(.COLS(COLS), .ROWS(ROWS), .DROP_TICKS(DT), .SPAWN_COL(SPAWN_COL)) dut (
        .CLK_50M(clk), .RST(rst), .game_state(gs),
        .left_key_press(lk), .right_key_press(rk), .down_key_press(dk),
        .disp(disp), .block_x(block_x), .block_y(block_y),
        .score(score), .line_clr(line_clr), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // After a landing, the whole post-landing sequence is precomputed as one snapshot per cycle.
    typedef struct {
        logic [N-1:0] g;
        bit           clr;
        int           sc;
        bit           spawn;
    } rec_t;

    rec_t         q[$];
    logic [N-1:0] m_grid = '0;
    int           m_x = SPAWN_COL, m_y = 0, m_cnt = 0, m_score = 0, m_mode = M_IDLE;
    bit           m_clr = 0, m_over = 0;

    function automatic logic [N-1:0] bitat(int x, int y);
        return N'(1) << (x * ROWS + y);
    endfunction

    function automatic bit occ(logic [N-1:0] g, int x, int y);
        return (g & bitat(x, y)) != '0;
    endfunction

    function automatic bit row_full(logic [N-1:0] g, int r);
        for (int c = 0; c < COLS; c++)
            if (!occ(g, c, r)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] clear_row(logic [N-1:0] g, int r);
        logic [N-1:0] o = g;
        for (int c = 0; c < COLS; c++) begin
            for (int k = r; k >= 1; k--)
                o = occ(g, c, k - 1) ? (o | bitat(c, k)) : (o & ~bitat(c, k));
            o = o & ~bitat(c, 0);
        end
        return o;
    endfunction

    task automatic plan_landing();
        logic [N-1:0] g = m_grid | bitat(m_x, m_y);
        int sc = m_score;
        q.push_back('{g, 1'b0, sc, 1'b0});
        if (CLR_EN) begin
            for (int r = ROWS - 1; r >= 0; r--) begin
                while (row_full(g, r)) begin
                    q.push_back('{g, 1'b0, sc, 1'b0});
                    g = clear_row(g, r);
                    if (sc < 65535) sc++;
                    q.push_back('{g, 1'b1, sc, 1'b0});
                end
                q.push_back('{g, 1'b0, sc, 1'b0});
            end
        end
        q.push_back('{g, 1'b0, sc, 1'b1});
    endtask

    task automatic model_clear();
        m_grid = '0; m_score = 0; m_over = 0; m_clr = 0;
        m_x = SPAWN_COL; m_y = 0; m_cnt = 0; m_mode = M_IDLE;
        q.delete();
    endtask

    task automatic model_edge();
        rec_t r;
        m_clr = 0;
        if (gs == 2'b00) begin
            model_clear();
        end else if (gs == 2'b01) begin
            case (m_mode)
                M_IDLE: begin
                    m_mode = M_PIPE;
                    q.push_back('{m_grid, 1'b0, m_score, 1'b1});
                end
                M_PIPE: begin
                    r = q.pop_front();
                    m_grid = r.g; m_clr = r.clr; m_score = r.sc;
                    if (r.spawn) begin
                        if (occ(m_grid, SPAWN_COL, 0)) begin
                            m_over = 1; m_mode = M_DEAD;
                        end else begin
                            m_x = SPAWN_COL; m_y = 0; m_cnt = 0; m_mode = M_FALLING;
                        end
                    end
                end
                M_FALLING: begin
                    if (m_cnt == DT - 1 || dk) begin
                        m_cnt = 0;
                        if (m_y == ROWS - 1 || occ(m_grid, m_x, m_y + 1)) begin
                            plan_landing();
                            m_mode = M_PIPE;
                        end else begin
                            m_y++;
                        end
                    end else begin
                        m_cnt++;
                        if (lk) begin
                            if (m_x > 0 && !occ(m_grid, m_x - 1, m_y)) m_x--;
                        end else if (rk) begin
                            if (m_x < COLS - 1 && !occ(m_grid, m_x + 1, m_y)) m_x++;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_clear();
        else model_edge();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("disp", disp, m_grid | ((m_mode == M_FALLING) ? bitat(m_x, m_y) : '0));
        chk("block_x", block_x, m_x);
        chk("block_y", block_y, m_y);
        chk("score", score, m_score);
        chk("line_clr", line_clr, m_clr);
        chk("game_over", game_over, m_over);
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input bit l, input bit r, input bit d);
        lk = l; rk = r; dk = d;
        @(negedge clk);
        lk = 0; rk = 0; dk = 0;
    endtask

    task automatic bound_chk(input string name, input int k, input int bound);
        n_checks++;
        if (k >= bound) begin
            n_err++;
            $display("FAIL %s: timeout after %0d cycles (required under %0d)", name, k, bound);
        end
    endtask

    task automatic wait_mode(input int want, input int bound, output int pulses);
        int k = 0;
        pulses = 0;
        while (m_mode != want && k < bound) begin
            @(negedge clk);
            if (line_clr === 1'b1) pulses++;
            k++;
        end
        bound_chk("wait_mode", k, bound);
    endtask

    task automatic drop();
        int k = 0;
        while (m_mode == M_FALLING && k < 40) begin
            pulse(0, 0, 1);
            k++;
        end
        bound_chk("drop", k, 40);
    endtask

    task automatic restart();
        int p;
        gs = 2'b00;
        @(negedge clk);
        gs = 2'b01;
        wait_mode(M_FALLING, 10, p);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_disp"}, disp, 0);
        chk({tag, "_x"}, block_x, SPAWN_COL);
        chk({tag, "_y"}, block_y, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_clr"}, line_clr, 0);
        chk({tag, "_over"}, game_over, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, k;
        rst = 0; gs = 2'b00; lk = 0; rk = 0; dk = 0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_reset("reset");

        // Spawn, gravity and first landing with hand-computed values.
        gs = 2'b01;
        repeat (2) @(negedge clk);
        chk("spawn_disp", disp, 32'h0000_0100);
        repeat (28) @(negedge clk);
        chk("fall_y", block_y, 7);
        chk("fall_disp", disp, 32'h0000_8000);
        repeat (4) @(negedge clk);
        chk("land_disp", disp, 32'h0000_0000);
        @(negedge clk);
        chk("settled_disp", disp, 32'h0000_8000);

        // Left wall, right wall, tick with left, then complete row 7.
        wait_mode(M_FALLING, 60, p);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        chk("left_wall_x", block_x, 0);
        drop();
        wait_mode(M_FALLING, 60, p);
        pulse(0, 1, 0); pulse(0, 1, 0); pulse(0, 1, 0);
        chk("right_wall_x", block_x, 3);
        drop();
        wait_mode(M_FALLING, 60, p);
        repeat (3) @(negedge clk);
        pulse(1, 0, 0);
        chk("tick_left_x", block_x, 1);
        chk("tick_left_y", block_y, 1);
        pulse(0, 1, 0);
        drop();
        wait_mode(M_FALLING, 60, p);
        chk("clr_pulses", p, CLR_EN ? 1 : 0);
        chk("clr_score", score, CLR_EN ? 1 : 0);
        chk("clr_disp", disp, CLR_EN ? 32'h0000_0100 : 32'h8080_8180);

        // Blocked left move, then row 6 content drops into row 7 on clear.
        restart();
        pulse(1, 0, 0);
        drop();
        wait_mode(M_FALLING, 60, p);
        k = 0;
        while (m_y < 7 && k < 20) begin
            pulse(0, 0, 1);
            k++;
        end
        bound_chk("descend", k, 20);
        pulse(1, 0, 0);
        chk("left_blocked_x", block_x, 1);
        chk("left_blocked_y", block_y, 7);
        drop();
        wait_mode(M_FALLING, 60, p);
        drop();
        wait_mode(M_FALLING, 60, p);
        pulse(0, 1, 0); pulse(0, 1, 0);
        drop();
        wait_mode(M_FALLING, 60, p);
        pulse(0, 1, 0);
        drop();
        wait_mode(M_FALLING, 60, p);
        chk("row6_disp", disp, CLR_EN ? 32'h0000_8100 : 32'h8080_C180);
        chk("row6_score", score, CLR_EN ? 1 : 0);

        // Freeze in OVER with keys active.
        gs = 2'b10;
        repeat (6) pulse(1, 0, 1);
        gs = 2'b01;

        // Stack column 1 until spawn is blocked.
        k = 0;
        while (m_mode != M_DEAD && k < 20) begin
            wait_mode(M_FALLING, 60, p);
            if (m_mode == M_FALLING) drop();
            while (m_mode == M_PIPE) @(negedge clk);
            k++;
        end
        bound_chk("stack", k, 20);
        chk("go_set", game_over, 1);
        repeat (10) @(negedge clk);
        chk("go_hold", game_over, 1);
        gs = 2'b00;
        @(negedge clk);
        chk("start_over", game_over, 0);
        chk("start_score", score, 0);
        chk("start_disp", disp, 0);

        // Asynchronous reset in the middle of a fall.
        restart();
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1 chk_reset("rst_fall");
        @(negedge clk);
        #2 rst = 0;

`ifdef ROW_CLEAR_EN
        // Asynchronous reset while a row shift is in progress.
        restart();
        pulse(1, 0, 0); drop();
        wait_mode(M_FALLING, 60, p); drop();
        wait_mode(M_FALLING, 60, p); pulse(0, 1, 0); drop();
        wait_mode(M_FALLING, 60, p); pulse(0, 1, 0); pulse(0, 1, 0); drop();
        k = 0;
        while (!(q.size() > 0 && q[0].clr) && k < 40) begin
            @(negedge clk);
            k++;
        end
        bound_chk("reach_shift", k, 40);
        #2 rst = 1;
        #1 chk_reset("rst_shift");
        @(negedge clk);
        #2 rst = 0;
`endif

        // Random play.
        @(negedge clk);
        gs = 2'b01;
        for (int i = 0; i < 3000; i++) begin
            lk = ($urandom_range(0, 99) < 20);
            rk = ($urandom_range(0, 99) < 20);
            dk = ($urandom_range(0, 99) < 12);
            if (m_mode == M_DEAD && $urandom_range(0, 7) == 0) gs = 2'b00;
            else if ($urandom_range(0, 99) == 0) gs = 2'($urandom_range(2, 3));
            else if ($urandom_range(0, 999) == 0) gs = 2'b00;
            else gs = 2'b01;
            @(negedge clk);
        end
        lk = 0; rk = 0; dk = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
